tick_bcd_counter: RTL
=====================

# tick_bcd_counter

Downstream consumer of the modulo divider's `mo` square wave. Detects each rising edge of `mo` as a tick and, while running, advances a two-digit BCD count 00–59 with a one-cycle wrap pulse. A debounced `btnC` toggles run/pause. It drives the seconds-style display digits on the board.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive clock samples at a new `btnC` level needed to accept it; legal range ≥1.

Ports:
- `clk` in 1: single system clock, rising-edge active.
- `reset` in 1: reset, asynchronous and active-low.
- `mo_in` in 1: divided square wave from the modulo divider, same clock domain.
- `btnC` in 1: raw pushbutton; each accepted press toggles run/pause.
- `clear` in 1: synchronous clear of the count.
- `ones` out 4: BCD ones digit, 0–9.
- `tens` out 4: BCD tens digit, 0–5.
- `running` out 1: 1 while counting is enabled.
- `tick` out 1: one-cycle pulse per detected `mo_in` rising edge.
- `wrap` out 1: one-cycle pulse when the count rolls from 59 to 00.

## Operation
- Reset (`reset`=0), immediate and asynchronous:
  - `ones`=0, `tens`=0, `running`=0, `tick`=0, `wrap`=0.
  - Debounce FSM enters REL with its counter at 0.
  - The edge-detect history register is set to 1, so an input already high at release produces no tick.
- Edge detect: `mo_d` ← `mo_s` every cycle. A rise is `mo_s`=1 and `mo_d`=0. `mo_s` is `mo_in` (see Configuration).
- Tick:
  - `tick` is a register. It is 1 for exactly the cycle after the edge at which the rise was sampled.
  - `tick` fires regardless of `running`.
- Count update, at the same edge that sets `tick`. Priority, highest first:
  1. `clear`=1 → `ones`=0, `tens`=0, `wrap`=0.
  2. Rise and `running`=1:
     - 59 → 00 with `wrap`=1.
     - `ones`=9 → `ones`=0, `tens`+1.
     - Otherwise `ones`+1.
  3. Otherwise hold, with `wrap`=0.
- Debounce FSM (counter width `$clog2(DEBOUNCE_CYCLES+1)`):
  - REL: when `btnC`=1 sampled, go to PCHK with count=1.
  - PCHK:
    - `btnC`=0 → back to REL, count=0.
    - `btnC`=1 → count+1.
    - On the `DEBOUNCE_CYCLES`-th consecutive high sample → go to HELD and toggle `running` at that edge.
  - HELD: when `btnC`=0 sampled, go to RCHK with count=1.
  - RCHK:
    - `btnC`=1 → back to HELD.
    - On the `DEBOUNCE_CYCLES`-th consecutive low sample → go to REL.
  - With `DEBOUNCE_CYCLES`=1, acceptance happens at the first sample, straight from REL/HELD.
- Simultaneous toggle and rise on one edge: the count decision uses `running` from before the toggle.
- Simultaneous `clear` and toggle: both take effect.

## Timing
- `mo_in` rise to count change: 1 clock edge without the macro; 3 with it. `tick` and `wrap` are aligned with the new count value.
- Accepted press to `running` change: 0 extra cycles. It toggles at the `DEBOUNCE_CYCLES`-th high sample.
- Bounce: any glitch shorter than `DEBOUNCE_CYCLES` samples is ignored.
- Minimum `mo_in` high or low time: 1 cycle without sync, 2 with sync. Back-to-back rises on consecutive cycles are impossible by construction.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `TICK_SYNC_EN` defined:
  - `mo_in` passes through a two-flop synchronizer before edge detect, giving `mo_s`.
  - Synchronizer flops reset to 1.
  - Adds 2 cycles of latency.
- Not defined:
  - `mo_s` = `mo_in` directly, for use when the divider shares `clk`.
  - Latency is 1 edge.

## Test plan
- Paused counting: reset, then `mo_in` square wave with period 12 (6 high, 6 low) for 5 periods.
  - 5 `tick` pulses, each 1 cycle wide.
  - `ones`/`tens` stay 0/0; `running`=0.
- Debounce, `DEBOUNCE_CYCLES`=4:
  - `btnC` high 3 cycles, then low → no toggle.
  - Then high 4 cycles → `running`=1 at the 4th edge.
  - A second press before 4 low samples → no toggle.
- Wrap: running, 60 rises.
  - Count reads 59 after the 59th rise.
  - The 60th rise gives `tens`=0, `ones`=0, `wrap`=1 for exactly that cycle.
- Clear collision: at count 23, `clear`=1 on the same edge as a rise.
  - Count becomes 00, `tick`=1, `wrap`=0.
  - The next rise gives 01.
- Reset mid-run: at count 37, running, drive `reset`=0 mid-cycle.
  - Outputs clear immediately, before the next edge.
  - Release with `mo_in`=1 → no tick until `mo_in` goes 0 then 1.
- Latency: a single rise of `mo_in`.
  - Without `TICK_SYNC_EN`: `tick`/count change at edge 1.
  - With `TICK_SYNC_EN`: at edge 3.

Source files
------------

// File: rtl/tick_bcd_counter.sv
// ---------------------------------------------------------------------------
// tick_bcd_counter
//
// Seconds-style display counter driven by the modulo divider's square wave.
// Every rising edge of mo_in becomes a one-cycle tick. While running, each
// tick advances a two-digit BCD count 00..59. The roll from 59 to 00 emits a
// one-cycle wrap pulse. A debounced push on btnC toggles run/pause.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive samples at a new btnC level needed to accept
//                    that level (>= 1)
//
// Optional build macro:
//   TICK_SYNC_EN     passes mo_in through a two-flop synchronizer before edge
//                    detect. This adds two cycles of tick latency. Leave it
//                    undefined when the divider runs on clk.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   mo_in    in   divided square wave
//   btnC     in   raw pushbutton, each accepted press toggles running
//   clear    in   synchronous clear of the count (wins over a tick)
//   ones     out  BCD ones digit 0..9
//   tens     out  BCD tens digit 0..5
//   running  out  counting enabled
//   tick     out  one-cycle pulse per detected mo_in rise
//   wrap     out  one-cycle pulse on 59 -> 00
//
// All outputs are flops. No input reaches an output without a register.
// ---------------------------------------------------------------------------
module tick_bcd_counter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mo_in,
  input  logic       btnC,
  input  logic       clear,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  // -------------------------------------------------------------------------
  // mo_in conditioning
  // -------------------------------------------------------------------------
  logic mo_s;   // wave as seen by the edge detector
  logic mo_d;   // previous mo_s
  logic rise;

`ifdef TICK_SYNC_EN
  // The synchronizer resets high. A wave that is already high at reset
  // release therefore looks like it has always been high, and no tick fires.
  logic [1:0] mo_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mo_pipe <= 2'b11;
    else        mo_pipe <= {mo_pipe[0], mo_in};
  end

  assign mo_s = mo_pipe[1];
`else
  assign mo_s = mo_in;
`endif

  assign rise = mo_s & ~mo_d;

  // -------------------------------------------------------------------------
  // Button debounce
  //   REL  : accepted level low
  //   PCHK : counting consecutive high samples
  //   HELD : accepted level high
  //   RCHK : counting consecutive low samples
  // A press is accepted on the DEBOUNCE_CYCLES-th high sample. At that same
  // edge 'press' is high, so running toggles with no extra cycle of delay.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {REL, PCHK, HELD, RCHK} db_state_t;

  db_state_t     db_st;
  logic [CW-1:0] db_cnt;
  logic          press;

  always_comb begin
    press = 1'b0;
    if (DEBOUNCE_CYCLES == 1) press = (db_st == REL) && btnC;
    else                      press = (db_st == PCHK) && btnC && (db_cnt == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_st  <= REL;
      db_cnt <= '0;
    end else begin
      case (db_st)
        REL: begin
          if (btnC) begin
            if (DEBOUNCE_CYCLES == 1) begin
              db_st  <= HELD;
              db_cnt <= '0;
            end else begin
              db_st  <= PCHK;
              db_cnt <= ONE;
            end
          end
        end
        PCHK: begin
          if (!btnC) begin
            db_st  <= REL;
            db_cnt <= '0;
          end else if (db_cnt == LAST) begin
            db_st  <= HELD;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + ONE;
          end
        end
        HELD: begin
          if (!btnC) begin
            if (DEBOUNCE_CYCLES == 1) begin
              db_st  <= REL;
              db_cnt <= '0;
            end else begin
              db_st  <= RCHK;
              db_cnt <= ONE;
            end
          end
        end
        RCHK: begin
          if (btnC) begin
            db_st  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == LAST) begin
            db_st  <= REL;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + ONE;
          end
        end
        default: begin
          db_st  <= REL;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Edge history, tick, run flag and BCD count
  // The count decision reads 'running' before this edge's toggle. Clear and
  // toggle are independent, so a collision applies both.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mo_d    <= 1'b1;
      tick    <= 1'b0;
      running <= 1'b0;
      ones    <= 4'd0;
      tens    <= 4'd0;
      wrap    <= 1'b0;
    end else begin
      mo_d    <= mo_s;
      tick    <= rise;
      running <= running ^ press;

      if (clear) begin
        ones <= 4'd0;
        tens <= 4'd0;
        wrap <= 1'b0;
      end else if (rise && running) begin
        if (ones == 4'd9) begin
          ones <= 4'd0;
          if (tens == 4'd5) begin
            tens <= 4'd0;
            wrap <= 1'b1;
          end else begin
            tens <= tens + 4'd1;
            wrap <= 1'b0;
          end
        end else begin
          ones <= ones + 4'd1;
          wrap <= 1'b0;
        end
      end else begin
        wrap <= 1'b0;
      end
    end
  end

endmodule
